// File: rtl/sift_out_pkg.sv
// Shared types and constants for the sift-out fault-management controller.
package sift_out_pkg;

    localparam int unsigned N_MODULES = 3;
    localparam int unsigned CNT_W     = 4;

    // System degradation level. SIMPLEX is kept in the encoding but never
    // entered on purpose; landing there is treated as a failure.
    typedef enum logic [1:0] {
        TMR     = 2'd0,
        DUPLEX  = 2'd1,
        SIMPLEX = 2'd2,
        FAILED  = 2'd3
    } state_t;

endpackage

// File: rtl/sift_out_fault_counter.sv
// Saturating consecutive-disagreement counter for one redundant module.
// o_hit looks at the value being loaded on the coming edge, so the owner can
// retire the module on the very edge the count reaches THRESH.
module sift_out_fault_counter
    import sift_out_pkg::*;
#(
    parameter int unsigned THRESH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_zero,
    input  logic i_hold,
    input  logic i_clr,
    output logic o_hit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // Next count: clear beats hold, hold beats increment/zero; saturate at all-ones.
    always_comb begin
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if (i_hold) begin
            w_count_nxt = r_count;
        end else if (i_inc) begin
            if (r_count != {CNT_W{1'b1}}) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end else if (i_zero) begin
            w_count_nxt = '0;
        end
    end

    assign o_hit = (w_count_nxt >= CNT_W'(THRESH));

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/sift_out_controller.sv
// Voter and degradation FSM for a triple-redundant bit-serial datapath.
//
// Handshakes: i_in_valid qualifies i_mod_out for one cycle; there is no ready,
// every valid sample is consumed and produces o_out_valid one cycle later.
// i_clr_req is a level request; its rising edge applies the clear and
// o_clr_ack pulses for exactly one cycle. The request must drop before the
// next one is recognised.
module sift_out_controller
    import sift_out_pkg::*;
#(
    parameter int unsigned THRESH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    input  logic [N_MODULES-1:0] i_mod_out,
    input  logic                 i_clr_req,
    output logic                 o_clr_ack,
    output logic                 o_out_valid,
    output logic                 o_out_bit,
    output logic [N_MODULES-1:0] o_retire_mask,
    output logic                 o_degraded,
    output logic                 o_fail,
    output state_t               o_state
);

    state_t               r_state;
    logic [N_MODULES-1:0] r_mask;
    logic                 r_fail;
    logic                 r_degraded;
    logic                 r_out_valid;
    logic                 r_out_bit;
    logic                 r_clr_ack;
    logic                 r_clr_req_d;

    logic [N_MODULES-1:0] w_active;
    logic [N_MODULES-1:0] w_sel;
    logic                 w_maj;
    logic                 w_dup_dis;
    logic                 w_dup_val;
    logic                 w_vote_bit;
    logic [N_MODULES-1:0] w_inc;
    logic [N_MODULES-1:0] w_zero;
    logic [N_MODULES-1:0] w_hold;
    logic [N_MODULES-1:0] w_hit;
    logic [N_MODULES-1:0] w_hit_act;
    logic                 w_multi_hit;
    logic                 w_clr_fire;
    logic                 w_frozen;

    assign w_active    = ~r_mask;
    assign w_sel       = i_mod_out & w_active;
    assign w_maj       = (i_mod_out[0] & i_mod_out[1]) | (i_mod_out[0] & i_mod_out[2])
                       | (i_mod_out[1] & i_mod_out[2]);
    // With exactly two modules active, parity of the active bits is disagreement.
    assign w_dup_dis   = ^w_sel;
    assign w_dup_val   = |w_sel;
    assign w_clr_fire  = i_clr_req & ~r_clr_req_d;
    assign w_frozen    = (r_state == FAILED) || (r_state == SIMPLEX);
    assign w_hit_act   = w_hit & w_active;
    assign w_multi_hit = |(w_hit_act & (w_hit_act - 3'd1));

    // Vote and per-module counter commands for the current state.
    always_comb begin
        w_vote_bit = 1'b0;
        w_inc      = '0;
        w_zero     = '0;
        unique case (r_state)
            TMR: begin
                w_vote_bit = w_maj;
                w_inc      = i_mod_out ^ {N_MODULES{w_maj}};
                w_zero     = ~w_inc;
            end
            DUPLEX: begin
                w_vote_bit = ~w_dup_dis & w_dup_val;
                w_inc      = {N_MODULES{w_dup_dis}} & w_active;
                w_zero     = {N_MODULES{~w_dup_dis}} & w_active;
            end
            default: begin
                w_vote_bit = 1'b0;
            end
        endcase
        w_hold = r_mask | {N_MODULES{~i_in_valid | w_frozen}};
    end

    for (genvar g = 0; g < N_MODULES; g++) begin : g_cnt
        sift_out_fault_counter #(
            .THRESH (THRESH)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (w_inc[g]),
            .i_zero  (w_zero[g]),
            .i_hold  (w_hold[g]),
            .i_clr   (w_clr_fire),
            .o_hit   (w_hit[g])
        );
    end

    // Degradation FSM, output collector and clear handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= TMR;
            r_mask      <= '0;
            r_fail      <= 1'b0;
            r_degraded  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_clr_ack   <= 1'b0;
            r_clr_req_d <= 1'b0;
        end else begin
            r_clr_req_d <= i_clr_req;
            r_clr_ack   <= w_clr_fire;
            r_out_valid <= i_in_valid;
            if (i_in_valid) begin
                r_out_bit <= w_vote_bit;
            end
            if (w_clr_fire) begin
                r_state    <= TMR;
                r_mask     <= '0;
                r_fail     <= 1'b0;
                r_degraded <= 1'b0;
            end else if (r_state == SIMPLEX) begin
                r_state    <= FAILED;
                r_fail     <= 1'b1;
                r_degraded <= 1'b1;
            end else if (i_in_valid) begin
                unique case (r_state)
                    TMR: begin
                        if (|w_hit_act) begin
                            r_mask     <= r_mask | w_hit_act;
                            r_degraded <= 1'b1;
                            if (w_multi_hit) begin
                                r_state <= FAILED;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state <= DUPLEX;
                            end
                        end
                    end
                    DUPLEX: begin
                        if (|w_hit_act) begin
                            r_state <= FAILED;
                            r_fail  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign o_clr_ack     = r_clr_ack;
    assign o_out_valid   = r_out_valid;
    assign o_out_bit     = r_out_bit;
    assign o_retire_mask = r_mask;
    assign o_degraded    = r_degraded;
    assign o_fail        = r_fail;
    assign o_state       = r_state;

endmodule

// File: tb/tb_sift_out_controller.sv
// Directed bench for sift_out_controller with THRESH=4.
module tb_sift_out_controller;
    import sift_out_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] mod_out;
    logic       clr_req;
    logic       clr_ack;
    logic       out_valid;
    logic       out_bit;
    logic [2:0] retire_mask;
    logic       degraded;
    logic       fail;
    state_t     state;

    int n_cmp = 0;
    int n_err = 0;

    sift_out_controller #(.THRESH(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .i_mod_out     (mod_out),
        .i_clr_req     (clr_req),
        .o_clr_ack     (clr_ack),
        .o_out_valid   (out_valid),
        .o_out_bit     (out_bit),
        .o_retire_mask (retire_mask),
        .o_degraded    (degraded),
        .o_fail        (fail),
        .o_state       (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [2:0] m, input logic c);
        @(negedge clk);
        in_valid = v;
        mod_out  = m;
        clr_req  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic ob,
                           input logic [2:0] mk, input logic dg, input logic fl,
                           input logic ak, input state_t st);
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
        chk({tag, ".out_bit"},   {7'd0, out_bit},   {7'd0, ob});
        chk({tag, ".mask"},      {5'd0, retire_mask}, {5'd0, mk});
        chk({tag, ".degraded"},  {7'd0, degraded},  {7'd0, dg});
        chk({tag, ".fail"},      {7'd0, fail},      {7'd0, fl});
        chk({tag, ".clr_ack"},   {7'd0, clr_ack},   {7'd0, ak});
        chk({tag, ".state"},     {6'd0, state},     {6'd0, st});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mod_out  = 3'b000;
        clr_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free TMR, alternating 0/1.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 2) ? 3'b111 : 3'b000, 1'b0);
            chk($sformatf("tmr%0d.bit", i), {7'd0, out_bit}, (i % 2) ? 8'd1 : 8'd0);
            chk($sformatf("tmr%0d.valid", i), {7'd0, out_valid}, 8'd1);
            chk($sformatf("tmr%0d.mask", i), {5'd0, retire_mask}, 8'd0);
        end
        step(1'b0, 3'b000, 1'b0);
        chk("idle.valid", {7'd0, out_valid}, 8'd0);

        // Intermittent fault on module 0: 3 wrong, 1 right, 3 wrong.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i == 3) ? 3'b000 : 3'b001, 1'b0);
            chk_all($sformatf("inter%0d", i), 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        end
        step(1'b1, 3'b000, 1'b0);

        // Module 2 stuck at 1: retired on the 4th sample's edge.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b100, 1'b0);
            chk_all($sformatf("stuck%0d", i), 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        end
        step(1'b1, 3'b100, 1'b0);
        chk_all("stuck3", 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, DUPLEX);

        // Retired module 2 ignored: 0/1 agree on 1.
        step(1'b1, 3'b011, 1'b0);
        chk_all("dup_agree1", 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, DUPLEX);
        step(1'b1, 3'b000, 1'b0);
        chk_all("dup_agree0", 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, DUPLEX);

        // Duplex disagreement: FAILED on the 4th.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b001, 1'b0);
            chk_all($sformatf("dupdis%0d", i), 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, DUPLEX);
        end
        step(1'b1, 3'b001, 1'b0);
        chk_all("dupdis3", 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, FAILED);
        step(1'b1, 3'b011, 1'b0);
        chk_all("failed_agree", 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, FAILED);
        step(1'b0, 3'b011, 1'b0);
        chk_all("failed_idle", 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, FAILED);

        // Clear with a concurrent sample: the sample is voted pre-clear.
        step(1'b1, 3'b111, 1'b1);
        chk_all("clr", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, TMR);
        step(1'b1, 3'b111, 1'b1);
        chk_all("clr_held", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        step(1'b0, 3'b000, 1'b0);
        chk("clr_drop.ack", {7'd0, clr_ack}, 8'd0);

        // Counter updates from a sample coinciding with clear are discarded.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b010, 1'b0);
        end
        step(1'b1, 3'b010, 1'b1);
        chk_all("clr_disc", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, TMR);
        step(1'b1, 3'b010, 1'b0);
        chk_all("clr_disc_next", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        step(1'b1, 3'b000, 1'b0);

        // Async reset with module 2's counter at 3.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b100, 1'b0);
        end
        chk("pre_rst.valid", {7'd0, out_valid}, 8'd1);
        @(negedge clk);
        in_valid = 1'b1;
        mod_out  = 3'b100;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        @(posedge clk);
        #1;
        chk("in_rst.valid", {7'd0, out_valid}, 8'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'b100, 1'b0);
        chk_all("post_rst", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);
        step(1'b1, 3'b100, 1'b0);
        chk_all("post_rst2", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, TMR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
